// File: rtl/axis_alu_pkg.sv
// Shared definitions for the dual-operand AXI-Stream ALU blocks and their
// operand pair transmitter: FSM state encoding, stream IDs and default width.
package axis_alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TID_W  = 2;

   localparam logic [TID_W-1:0] TID_A = 2'd0;
   localparam logic [TID_W-1:0] TID_B = 2'd1;

   typedef enum logic [1:0] {
      WAIT_A,
      WAIT_B,
      ISSUE
   } pair_state_t;

endpackage

// File: rtl/axis_operand_pair_tx.sv
// De-interleaves one operand stream (A word, then B word) into two master
// streams whose valids rise and fall together, as the ALU slave ports need.
// Optional build macro TID_CHECK_EN: drop and flag words whose tid does not
// match the expected operand slot; otherwise order alone defines A/B.
module axis_operand_pair_tx #(
   parameter int unsigned DATA_W = axis_alu_pkg::DATA_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   // interleaved operand input
   input  logic [DATA_W-1:0]              s_tdata,
   input  logic                           s_tvalid,
   output logic                           s_tready,
   input  logic                           s_tlast,
   input  logic [axis_alu_pkg::TID_W-1:0] s_tid,
   // operand A output
   output logic [DATA_W-1:0]              a_tdata,
   output logic                           a_tvalid,
   input  logic                           a_tready,
   output logic                           a_tlast,
   output logic [axis_alu_pkg::TID_W-1:0] a_tid,
   // operand B output
   output logic [DATA_W-1:0]              b_tdata,
   output logic                           b_tvalid,
   input  logic                           b_tready,
   output logic                           b_tlast,
   output logic [axis_alu_pkg::TID_W-1:0] b_tid,
   // status
   output logic [CNT_W-1:0]               pair_cnt,
   output logic                           err
);

   import axis_alu_pkg::*;

   pair_state_t       state_q, state_d;
   logic [DATA_W-1:0] hold_a_q, hold_a_d;
   logic [DATA_W-1:0] hold_b_q, hold_b_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              accept;
   logic              s_hs;
   logic              drop_a;
   logic              drop_b;

`ifdef TID_CHECK_EN
   // A slot takes only tid==TID_A without tlast; B slot only tid==TID_B.
   assign drop_a = (s_tid != TID_A) || s_tlast;
   assign drop_b = (s_tid != TID_B);
`else
   logic unused_tid;
   assign unused_tid = ^s_tid;
   assign drop_a     = 1'b0;
   assign drop_b     = 1'b0;
`endif

   // both sinks must take the pair in the same cycle
   assign accept = (state_q == ISSUE) && a_tready && b_tready;
   assign s_hs   = s_tvalid && s_tready;

   assign a_tvalid = (state_q == ISSUE);
   assign b_tvalid = (state_q == ISSUE);
   assign a_tdata  = hold_a_q;
   assign b_tdata  = hold_b_q;
   assign a_tlast  = last_q;
   assign b_tlast  = last_q;
   assign a_tid    = TID_A;
   assign b_tid    = TID_B;
   assign pair_cnt = cnt_q;
   assign err      = err_q;

   // input ready: always open while collecting, only on joint accept in ISSUE
   always_comb begin
      s_tready = 1'b1;
      if (state_q == ISSUE) begin
         s_tready = accept;
      end
   end

   // next-state, operand capture, pair counting and drop flag
   always_comb begin
      state_d  = state_q;
      hold_a_d = hold_a_q;
      hold_b_d = hold_b_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (s_hs) begin
               if (drop_a) begin
                  err_d = 1'b1;
               end else begin
                  hold_a_d = s_tdata;
                  state_d  = WAIT_B;
               end
            end
         end
         WAIT_B: begin
            if (s_hs) begin
               if (drop_b) begin
                  err_d = 1'b1;
               end else begin
                  hold_b_d = s_tdata;
                  last_d   = s_tlast;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (accept) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = WAIT_A;
               // the next A word may land in the same cycle the pair leaves
               if (s_hs) begin
                  if (drop_a) begin
                     err_d = 1'b1;
                  end else begin
                     hold_a_d = s_tdata;
                     state_d  = WAIT_B;
                  end
               end
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   // state and holding registers; reset discards any partial or pending pair
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= WAIT_A;
         hold_a_q <= '0;
         hold_b_q <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_a_q <= hold_a_d;
         hold_b_q <= hold_b_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_axis_operand_pair_tx.sv
// Directed bench for axis_operand_pair_tx with a pair scoreboard and a
// cycle model of the transmitter; a second instance with CNT_W=4 shares the
// stimulus to observe counter wrap.
module tb_axis_operand_pair_tx;
   import axis_alu_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        last;
   } pair_t;

   logic              aclk;
   logic              aresetn;
   logic [31:0]       s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic [TID_W-1:0]  s_tid;
   logic [31:0]       a_tdata, b_tdata;
   logic              a_tvalid, b_tvalid;
   logic              a_tready, b_tready;
   logic              a_tlast, b_tlast;
   logic [TID_W-1:0]  a_tid, b_tid;
   logic [15:0]       pair_cnt;
   logic              err;

   logic              d4_s_tready;
   logic [31:0]       d4_a_tdata, d4_b_tdata;
   logic              d4_a_tvalid, d4_b_tvalid;
   logic              d4_a_tlast, d4_b_tlast;
   logic [TID_W-1:0]  d4_a_tid, d4_b_tid;
   logic [3:0]        pair_cnt4;
   logic              d4_err;

   int          ncmp = 0;
   int          nfail = 0;
   bit          mon_en = 0;
   int          mstate = 0;
   logic [31:0] ma = '0;
   pair_t       q[$];
   int unsigned exp_cnt = 0;
   bit          exp_err = 0;
   bit          hs_last = 0;

   axis_operand_pair_tx #(.DATA_W(32), .CNT_W(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tlast(s_tlast), .s_tid(s_tid),
      .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
      .a_tlast(a_tlast), .a_tid(a_tid),
      .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
      .b_tlast(b_tlast), .b_tid(b_tid),
      .pair_cnt(pair_cnt), .err(err)
   );

   axis_operand_pair_tx #(.DATA_W(32), .CNT_W(4)) dut4 (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(d4_s_tready),
      .s_tlast(s_tlast), .s_tid(s_tid),
      .a_tdata(d4_a_tdata), .a_tvalid(d4_a_tvalid), .a_tready(a_tready),
      .a_tlast(d4_a_tlast), .a_tid(d4_a_tid),
      .b_tdata(d4_b_tdata), .b_tvalid(d4_b_tvalid), .b_tready(b_tready),
      .b_tlast(d4_b_tlast), .b_tid(d4_b_tid),
      .pair_cnt(pair_cnt4), .err(d4_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // compare outputs against the model, then advance the model by one edge
   task automatic monitor();
      bit    exp_srdy, acc, hs, dropa, dropb;
      pair_t p;
      exp_srdy = (mstate != 2) || (a_tready && b_tready);
      chk("a_tvalid", a_tvalid, mstate == 2);
      chk("b_tvalid", b_tvalid, mstate == 2);
      chk("s_tready", s_tready, exp_srdy);
      chk("pair_cnt", pair_cnt, exp_cnt[15:0]);
      chk("pair_cnt4", pair_cnt4, exp_cnt[3:0]);
      chk("err", err, exp_err);
      chk("a_tid", a_tid, 0);
      chk("b_tid", b_tid, 1);
      if (mstate == 2) begin
         chk("sb_nonempty", q.size() > 0, 1);
         if (q.size() > 0) begin
            p = q[0];
            chk("a_tdata", a_tdata, p.a);
            chk("b_tdata", b_tdata, p.b);
            chk("a_tlast", a_tlast, p.last);
            chk("b_tlast", b_tlast, p.last);
         end
      end
      hs = s_tvalid && exp_srdy;
      hs_last = hs;
      if (!aresetn) begin
         mstate  = 0;
         q.delete();
         exp_cnt = 0;
         exp_err = 0;
      end else begin
         exp_err = 0;
`ifdef TID_CHECK_EN
         dropa = (s_tid != 0) || s_tlast;
         dropb = (s_tid != 1);
`else
         dropa = 0;
         dropb = 0;
`endif
         acc = (mstate == 2) && a_tready && b_tready;
         if (acc) begin
            void'(q.pop_front());
            exp_cnt++;
            mstate = 0;
         end
         if (mstate == 1) begin
            if (hs) begin
               if (dropb) exp_err = 1;
               else begin
                  q.push_back('{a: ma, b: s_tdata, last: s_tlast});
                  mstate = 2;
               end
            end
         end else if (mstate == 0) begin
            if (hs) begin
               if (dropa) exp_err = 1;
               else begin
                  ma = s_tdata;
                  mstate = 1;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge aclk);
      if (mon_en) monitor();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [TID_W-1:0] tid, input logic last);
      int n;
      n = 0;
      s_tdata  = d;
      s_tid    = tid;
      s_tlast  = last;
      s_tvalid = 1'b1;
      do begin
         cycle();
         n++;
      end while (!hs_last && n < 50);
      chk("send_handshake", hs_last, 1);
   endtask

   task automatic idle_cycles(input int n);
      s_tvalid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      aresetn  = 1'b0;
      cycle();
      aresetn  = 1'b1;
   endtask

   initial begin
      int          t0;
      logic [31:0] da, db;
      aresetn  = 1'b0;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tid    = '0;
      a_tready = 1'b1;
      b_tready = 1'b1;
      repeat (3) cycle();
      aresetn = 1'b1;

      // reset state
      chk("rst_a_tvalid", a_tvalid, 0);
      chk("rst_b_tvalid", b_tvalid, 0);
      chk("rst_a_tdata", a_tdata, 0);
      chk("rst_b_tdata", b_tdata, 0);
      chk("rst_a_tlast", a_tlast, 0);
      chk("rst_b_tlast", b_tlast, 0);
      chk("rst_pair_cnt", pair_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_s_tready", s_tready, 1);
      mon_en = 1;

      // single pair, one cycle from B handshake to valid
      send(32'h40A00000, 0, 1'b0);
      send(32'h3F800000, 1, 1'b1);
      s_tvalid = 1'b0;
      chk("t1_a_tvalid", a_tvalid, 1);
      chk("t1_a_tdata", a_tdata, 32'h40A00000);
      chk("t1_b_tdata", b_tdata, 32'h3F800000);
      chk("t1_tlast", {a_tlast, b_tlast}, 2'b11);
      cycle();
      chk("t1_valid_drop", a_tvalid, 0);
      chk("t1_pair_cnt", pair_cnt, 1);

      // one sink stalls: pair held, nothing consumed
      do_reset();
      a_tready = 1'b1;
      b_tready = 1'b0;
      send(32'h40A00000, 0, 1'b0);
      send(32'h3F800000, 1, 1'b1);
      idle_cycles(5);
      chk("t2_hold_valid", {a_tvalid, b_tvalid}, 2'b11);
      chk("t2_hold_srdy", s_tready, 0);
      chk("t2_hold_cnt", pair_cnt, 0);
      b_tready = 1'b1;
      cycle();
      chk("t2_accept_cnt", pair_cnt, 1);
      chk("t2_after_valid", a_tvalid, 0);

      // 100 back-to-back pairs at one pair per two beats
      do_reset();
      t0 = $time;
      for (int i = 0; i < 100; i++) begin
         da = $urandom;
         db = $urandom;
         send(da, 0, 1'b0);
         send(db, 1, (i % 7) == 3);
      end
      chk("t3_beat_rate", ($time - t0) / 10, 200);
      idle_cycles(2);
      chk("t3_pair_cnt", pair_cnt, 100);
      chk("t3_sb_empty", q.size(), 0);

      // 17 pairs through the 4-bit counter instance
      do_reset();
      for (int i = 0; i < 17; i++) begin
         send(32'h1000 + i, 0, 1'b0);
         send(32'h2000 + i, 1, 1'b0);
      end
      idle_cycles(2);
      chk("t4_cnt4_wrap", pair_cnt4, 1);
      chk("t4_cnt16", pair_cnt, 17);

      // reset after a lone A word: that word must never surface
      do_reset();
      send(32'hDEADBEEF, 0, 1'b0);
      do_reset();
      idle_cycles(2);
      chk("t5_no_output", a_tvalid, 0);
      send(32'h11111111, 0, 1'b0);
      send(32'h22222222, 1, 1'b0);
      s_tvalid = 1'b0;
      chk("t5_fresh_a", a_tdata, 32'h11111111);
      chk("t5_fresh_b", b_tdata, 32'h22222222);
      idle_cycles(2);
      chk("t5_pair_cnt", pair_cnt, 1);

`ifndef TID_CHECK_EN
      // tlast on the A word is stored as data only; B's tlast=0 wins
      do_reset();
      send(32'hAAAA0001, 0, 1'b1);
      send(32'hBBBB0001, 1, 1'b0);
      s_tvalid = 1'b0;
      chk("tl_a_tlast", a_tlast, 0);
      chk("tl_a_tdata", a_tdata, 32'hAAAA0001);
      idle_cycles(2);
`else
      // tid order 1,0,0,1: words 1 and 3 dropped with err
      do_reset();
      send(32'h00000011, 1, 1'b0);
      chk("t6_err_first", err, 1);
      send(32'h00000022, 0, 1'b0);
      chk("t6_err_clear", err, 0);
      send(32'h00000033, 0, 1'b0);
      chk("t6_err_third", err, 1);
      send(32'h00000044, 1, 1'b1);
      s_tvalid = 1'b0;
      chk("t6_a_tdata", a_tdata, 32'h00000022);
      chk("t6_b_tdata", b_tdata, 32'h00000044);
      idle_cycles(2);
      chk("t6_pair_cnt", pair_cnt, 1);
`endif

      chk("final_sb_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
